// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch queue: exception codes,
// FSM state encoding and the packed FIFO entry layout {pc, instr, exc}.
package fetch_pkg;

  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_ABORT    = 2'b10;

  localparam int FQ_W = 66;

  typedef enum logic [1:0] {
    RUN  = 2'b00,
    SKIP = 2'b01,
    HALT = 2'b10
  } fq_state_t;

  // Pack one FIFO entry: PC in the top word, instruction below, exception code in the LSBs.
  function automatic logic [FQ_W-1:0] make_entry(input logic [31:0] pc,
                                                 input logic [31:0] instr,
                                                 input logic [1:0]  exc);
    return {pc, instr, exc};
  endfunction

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// Synchronous FIFO whose head entry sits in an output register, so a word
// pushed in one cycle appears on out_data the next. flush empties it at once.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_next;
  logic             push_ok;
  logic             pop_ok;
  logic [CW-1:0]    remain;
  logic [CW-1:0]    count_next;
  logic             valid_next;
  logic [WIDTH-1:0] data_next;

  // Work out accepted push/pop and what the head register must hold next cycle.
  always_comb begin
    pop_ok     = pop & out_valid & ~flush;
    push_ok    = push & ~flush & ((count != CW'(DEPTH)) | pop_ok);
    rd_next    = rd_ptr + AW'(pop_ok);
    remain     = count - CW'(pop_ok);
    count_next = remain + CW'(push_ok);
    valid_next = 1'b0;
    data_next  = out_data;
    if (flush) begin
      valid_next = 1'b0;
      data_next  = out_data;
    end else if (count_next == {CW{1'b0}}) begin
      valid_next = 1'b0;
      data_next  = out_data;
    end else if (push_ok && (remain == {CW{1'b0}})) begin
      // Queue was (or became) empty: the incoming word lands straight in the head.
      valid_next = 1'b1;
      data_next  = push_data;
    end else begin
      valid_next = 1'b1;
      data_next  = mem[rd_next];
    end
  end

  // Storage array write port; no reset needed since count guards every read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer, occupancy and head-register update with synchronous reset and flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= {AW{1'b0}};
      wr_ptr    <= {AW{1'b0}};
      count     <= {CW{1'b0}};
      out_valid <= 1'b0;
      out_data  <= {WIDTH{1'b0}};
    end else if (flush) begin
      rd_ptr    <= {AW{1'b0}};
      wr_ptr    <= {AW{1'b0}};
      count     <= {CW{1'b0}};
      out_valid <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr    <= rd_next;
      count     <= count_next;
      out_valid <= valid_next;
      out_data  <= data_next;
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Fetch queue: owns the fetch PC, tags fetched words with PC and exception
// code, buffers them for decode, and drops a stale response after a redirect.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH       = 4,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          SKIP_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [31:0]            fetch_pc,
  output logic                   fetch_en,
  input  logic                   fetch_ready,
  input  logic [31:0]            fetch_instr,
  input  logic                   fetch_misaligned,
  input  logic                   fetch_abort,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic                   dec_valid,
  input  logic                   dec_ready,
  output logic [31:0]            dec_instr,
  output logic [31:0]            dec_pc,
  output logic [1:0]             dec_exc,
  output logic [$clog2(DEPTH):0] q_count,
  output logic                   overflow
);

  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int SKIP_W = (SKIP_CYCLES > 1) ? $clog2(SKIP_CYCLES) : 1;

  fq_state_t         state;
  fq_state_t         state_next;
  logic [31:0]       pc_next;
  logic [SKIP_W-1:0] skip_cnt;
  logic [SKIP_W-1:0] skip_next;
  logic              skip_last;
  logic              ovf_next;
  logic              push_req;
  logic              push;
  logic              pop;
  logic              full_blocked;
  logic [FQ_W-1:0]   push_entry;
  logic [FQ_W-1:0]   head;
  logic [CW-1:0]     count_next;
  logic              fetch_en_next;

  assign dec_pc    = head[65:34];
  assign dec_instr = head[33:2];
  assign dec_exc   = head[1:0];

  // Decide next state, next PC and the entry to push; redirect overrides everything.
  always_comb begin
    state_next   = state;
    pc_next      = fetch_pc;
    skip_next    = skip_cnt;
    push_req     = 1'b0;
    push_entry   = make_entry(fetch_pc, 32'h0000_0000, EXC_NONE);
    pop          = dec_valid & dec_ready & ~redirect_valid;
    // A push only fits in a full queue if decode frees the head this same cycle.
    full_blocked = (q_count == CW'(DEPTH)) & ~pop;
    skip_last    = (32'(skip_cnt) >= (SKIP_CYCLES - 1));
    if (redirect_valid) begin
      pc_next    = redirect_pc;
      skip_next  = {SKIP_W{1'b0}};
      state_next = (SKIP_CYCLES == 0) ? RUN : SKIP;
    end else begin
      case (state)
        RUN: begin
          if (fetch_abort) begin
            push_req   = 1'b1;
            push_entry = make_entry(fetch_pc, 32'h0000_0000, EXC_ABORT);
            state_next = HALT;
          end else if (fetch_misaligned && fetch_en) begin
            push_req   = 1'b1;
            push_entry = make_entry(fetch_pc, 32'h0000_0000, EXC_MISALIGN);
            state_next = HALT;
          end else if (fetch_ready) begin
            push_req   = 1'b1;
            push_entry = make_entry(fetch_pc, fetch_instr, EXC_NONE);
            pc_next    = full_blocked ? fetch_pc : (fetch_pc + 32'd4);
          end else begin
            state_next = RUN;
          end
        end
        SKIP: begin
          // The first response after a redirect belongs to the old stream.
          if (fetch_ready || fetch_abort) begin
            state_next = RUN;
          end else if (skip_last) begin
            state_next = RUN;
          end else begin
            skip_next = skip_cnt + SKIP_W'(1);
          end
        end
        HALT: begin
          state_next = HALT;
        end
        default: begin
          state_next = RUN;
        end
      endcase
    end
    push          = push_req & ~full_blocked;
    ovf_next      = overflow | (push_req & full_blocked);
    count_next    = redirect_valid ? {CW{1'b0}} : (q_count - CW'(pop) + CW'(push));
    // Keep one slot free for a response that may already be in flight.
    fetch_en_next = (state_next != HALT) && (count_next <= CW'(DEPTH - 2));
  end

  // State, PC, skip window, sticky overflow and fetch enable registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      fetch_pc <= RESET_PC;
      skip_cnt <= {SKIP_W{1'b0}};
      overflow <= 1'b0;
      fetch_en <= 1'b0;
    end else begin
      state    <= state_next;
      fetch_pc <= pc_next;
      skip_cnt <= skip_next;
      overflow <= ovf_next;
      fetch_en <= fetch_en_next;
    end
  end

  sync_fifo #(
    .WIDTH (FQ_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .out_valid (dec_valid),
    .out_data  (head),
    .count     (q_count)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: expected entries are queued as the
// bench drives fetch responses and compared when decode pops the head.
module tb_fetch_queue;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        fetch_en;
  logic        fetch_ready;
  logic [31:0] fetch_instr;
  logic        fetch_misaligned;
  logic        fetch_abort;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [1:0]  dec_exc;
  logic [2:0]  q_count;
  logic        overflow;

  logic [65:0] sb[$];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fetch_queue #(
    .DEPTH       (4),
    .RESET_PC    (32'h0000_0000),
    .SKIP_CYCLES (2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .fetch_pc         (fetch_pc),
    .fetch_en         (fetch_en),
    .fetch_ready      (fetch_ready),
    .fetch_instr      (fetch_instr),
    .fetch_misaligned (fetch_misaligned),
    .fetch_abort      (fetch_abort),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .dec_valid        (dec_valid),
    .dec_ready        (dec_ready),
    .dec_instr        (dec_instr),
    .dec_pc           (dec_pc),
    .dec_exc          (dec_exc),
    .q_count          (q_count),
    .overflow         (overflow)
  );

  task automatic check_val(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; a handshake seen before the edge pops and checks the scoreboard.
  task automatic tick();
    if (dec_valid && dec_ready) begin
      check_val("sb_has_entry", 66'(sb.size() != 0), 66'd1);
      if (sb.size() != 0) begin
        check_val("dec_entry", {dec_pc, dec_instr, dec_exc}, sb.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [31:0] instr, input logic [31:0] pc, input bit accept);
    fetch_ready = 1'b1;
    fetch_instr = instr;
    if (accept) sb.push_back({pc, instr, EXC_NONE});
    tick();
    fetch_ready = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] pc, input int idle);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
    sb.delete();
    for (int i = 0; i < idle; i++) tick();
  endtask

  task automatic do_reset();
    dec_ready = 1'b0; fetch_ready = 1'b0; fetch_abort = 1'b0;
    fetch_misaligned = 1'b0; redirect_valid = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    sb.delete();
    tick();
  endtask

  initial begin
    rst = 1'b1; fetch_ready = 1'b0; fetch_instr = 32'h0; fetch_misaligned = 1'b0;
    fetch_abort = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; dec_ready = 1'b0;
    #1;
    tick();
    tick();
    check_val("rst_fetch_pc", 66'(fetch_pc), 66'h0);
    check_val("rst_fetch_en", 66'(fetch_en), 66'd0);
    check_val("rst_dec", {dec_valid, dec_pc, dec_instr, dec_exc}, 66'h0);
    check_val("rst_q_count", 66'(q_count), 66'd0);
    check_val("rst_overflow", 66'(overflow), 66'd0);
    rst = 1'b0;
    tick();
    check_val("post_rst_fetch_en", 66'(fetch_en), 66'd1);

    // Streaming: three words, each visible one cycle after its push.
    dec_ready = 1'b1;
    pulse(32'hAAAA_0001, 32'h0, 1'b1);
    check_val("lat_a_valid", 66'(dec_valid), 66'd1);
    check_val("lat_a_pc", 66'(dec_pc), 66'h0);
    tick();
    pulse(32'hBBBB_0002, 32'h4, 1'b1);
    check_val("lat_b_pc", 66'(dec_pc), 66'h4);
    tick();
    pulse(32'hCCCC_0003, 32'h8, 1'b1);
    check_val("lat_c_pc", 66'(dec_pc), 66'h8);
    tick();
    check_val("stream_pc", 66'(fetch_pc), 66'hC);
    check_val("stream_empty", 66'(q_count), 66'd0);

    // Fill with decode stalled, then overflow on a fifth response.
    do_reset();
    pulse(32'h1000_0000, 32'h0, 1'b1);
    pulse(32'h1000_0001, 32'h4, 1'b1);
    check_val("fill2_fetch_en", 66'(fetch_en), 66'd1);
    check_val("fill2_q_count", 66'(q_count), 66'd2);
    pulse(32'h1000_0002, 32'h8, 1'b1);
    check_val("fill3_fetch_en", 66'(fetch_en), 66'd0);
    check_val("fill3_q_count", 66'(q_count), 66'd3);
    pulse(32'h1000_0003, 32'hC, 1'b1);
    check_val("fill4_q_count", 66'(q_count), 66'd4);
    check_val("fill4_overflow", 66'(overflow), 66'd0);
    pulse(32'h1000_0004, 32'h10, 1'b0);
    check_val("ovf_set", 66'(overflow), 66'd1);
    check_val("ovf_q_count", 66'(q_count), 66'd4);
    check_val("ovf_fetch_pc", 66'(fetch_pc), 66'h10);
    check_val("stall_hold_pc", 66'(dec_pc), 66'h0);
    dec_ready = 1'b1;
    repeat (4) tick();
    check_val("drain_q_count", 66'(q_count), 66'd0);
    check_val("ovf_sticky", 66'(overflow), 66'd1);

    // Full queue: simultaneous pop and push both succeed.
    do_reset();
    pulse(32'h2000_0000, 32'h0, 1'b1);
    pulse(32'h2000_0001, 32'h4, 1'b1);
    pulse(32'h2000_0002, 32'h8, 1'b1);
    pulse(32'h2000_0003, 32'hC, 1'b1);
    dec_ready = 1'b1;
    pulse(32'h2000_0004, 32'h10, 1'b1);
    check_val("full_pp_q_count", 66'(q_count), 66'd4);
    check_val("full_pp_overflow", 66'(overflow), 66'd0);
    check_val("full_pp_fetch_pc", 66'(fetch_pc), 66'h14);
    repeat (4) tick();
    check_val("full_pp_drained", 66'(q_count), 66'd0);

    // Redirect flushes; the next response is stale and dropped.
    do_reset();
    pulse(32'h3000_0000, 32'h0, 1'b1);
    pulse(32'h3000_0001, 32'h4, 1'b1);
    redirect(32'h0000_0100, 0);
    check_val("redir_dec_valid", 66'(dec_valid), 66'd0);
    check_val("redir_q_count", 66'(q_count), 66'd0);
    check_val("redir_fetch_pc", 66'(fetch_pc), 66'h100);
    pulse(32'hDEAD_0000, 32'h0, 1'b0);
    check_val("skip_drop_q", 66'(q_count), 66'd0);
    check_val("skip_drop_pc", 66'(fetch_pc), 66'h100);
    pulse(32'h3000_0100, 32'h100, 1'b1);
    check_val("after_skip_valid", 66'(dec_valid), 66'd1);
    check_val("after_skip_pc", 66'(dec_pc), 66'h100);
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    check_val("after_skip_fetch_pc", 66'(fetch_pc), 66'h104);

    // Skip window expires with no response: next response is kept.
    redirect(32'h0000_0200, 2);
    pulse(32'h3000_0200, 32'h200, 1'b1);
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    check_val("skip_timeout_pc", 66'(fetch_pc), 66'h204);

    // PC wraps modulo 2^32.
    redirect(32'hFFFF_FFFC, 2);
    pulse(32'h3000_FFFC, 32'hFFFF_FFFC, 1'b1);
    check_val("wrap_fetch_pc", 66'(fetch_pc), 66'h0);
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;

    // Misaligned target: one exception entry, then halted.
    redirect(32'h0000_0102, 2);
    fetch_misaligned = 1'b1;
    sb.push_back({32'h0000_0102, 32'h0, EXC_MISALIGN});
    tick();
    fetch_misaligned = 1'b0;
    check_val("mis_fetch_en", 66'(fetch_en), 66'd0);
    check_val("mis_dec_valid", 66'(dec_valid), 66'd1);
    check_val("mis_fetch_pc", 66'(fetch_pc), 66'h102);
    dec_ready = 1'b1;
    tick();
    pulse(32'h4000_0000, 32'h0, 1'b0);
    fetch_abort = 1'b1;
    tick();
    fetch_abort = 1'b0;
    pulse(32'h4000_0001, 32'h0, 1'b0);
    check_val("halt_q_count", 66'(q_count), 66'd0);
    check_val("halt_dec_valid", 66'(dec_valid), 66'd0);
    check_val("halt_fetch_en", 66'(fetch_en), 66'd0);
    dec_ready = 1'b0;

    // Abort beats a same-cycle response; reset clears the halt.
    redirect(32'h0000_0020, 2);
    check_val("redir_exit_halt", 66'(fetch_en), 66'd1);
    fetch_abort = 1'b1;
    fetch_ready = 1'b1;
    fetch_instr = 32'h5555_5555;
    sb.push_back({32'h0000_0020, 32'h0, EXC_ABORT});
    tick();
    fetch_abort = 1'b0;
    fetch_ready = 1'b0;
    check_val("abort_exc", 66'(dec_exc), 66'(EXC_ABORT));
    check_val("abort_instr", 66'(dec_instr), 66'h0);
    check_val("abort_fetch_pc", 66'(fetch_pc), 66'h20);
    check_val("abort_fetch_en", 66'(fetch_en), 66'd0);
    do_reset();
    check_val("halt_rst_pc", 66'(fetch_pc), 66'h0);
    check_val("halt_rst_q", 66'(q_count), 66'd0);
    check_val("halt_rst_valid", 66'(dec_valid), 66'd0);
    check_val("halt_rst_fetch_en", 66'(fetch_en), 66'd1);

    check_val("sb_empty", 66'(sb.size()), 66'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
